// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and small decode helpers.
// Raster blocks import this so every layer agrees on the same window math.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_H_VIS   = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_VIS   = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    localparam int H_TOTAL     = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL     = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HSYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int HSYNC_END   = HSYNC_START + DEF_H_SYNC;
    localparam int VSYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int VSYNC_END   = VSYNC_START + DEF_V_SYNC;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// System-clock divider producing a registered one-clock pixel strobe.
// With CLK_DIV = 1 the strobe sits high continuously once out of reset.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Strobe is registered from the next count so it lines up with cnt_q == LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel divider, x/y counters, sync/blank decode and
// line/frame strobes, all registered so x/y and their decodes change together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam coord_t X_MAX    = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t Y_MAX    = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t X_VIS    = coord_t'(H_VIS);
    localparam coord_t Y_VIS    = coord_t'(V_VIS);
    localparam coord_t HS_BEG   = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_BEG   = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

    logic   tick;
    logic   x_wrap;
    coord_t x_q, x_d, y_q, y_d;
    logic   von_q, hs_q, vs_q, line_q, frame_q;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_pixel_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign x_wrap = tick && (x_q == X_MAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            x_d = x_wrap ? '0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = (y_q == Y_MAX) ? '0 : y_q + 10'd1;
            end
        end
    end

    // Decodes use x_d/y_d so they land on the same edge as the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            von_q   <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            von_q   <= (x_d < X_VIS) && (y_d < Y_VIS);
            hs_q    <= in_window(x_d, HS_BEG, HS_END) ? SYNC_POL : ~SYNC_POL;
            vs_q    <= in_window(y_d, VS_BEG, VS_END) ? SYNC_POL : ~SYNC_POL;
            line_q  <= x_wrap;
            frame_q <= x_wrap && (y_q == Y_MAX);
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign video_on   = von_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign pixel_tick = tick;
    assign line_tick  = line_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (15x8) so whole frames fit
// in a short run; a second instance covers the CLK_DIV = 1 build.
module tb_vga_timing_gen;

    localparam int D   = 3;
    localparam int HV  = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VV  = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int HT  = HV + HFP + HSW + HBP;
    localparam int VT  = VV + VFP + VSW + VBP;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von, hs, vs, pt, lt, ft;
    } obs_t;

    typedef struct {
        int   n;
        obs_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] x0, y0, x1, y1;
    logic von0, hs0, vs0, pt0, lt0, ft0;
    logic von1, hs1, vs1, pt1, lt1, ft1;
    obs_t obs0, obs1;

    assign obs0 = {x0, y0, von0, hs0, vs0, pt0, lt0, ft0};
    assign obs1 = {x1, y1, von1, hs1, vs1, pt1, lt1, ft1};

    vga_timing_gen #(.CLK_DIV(D), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                     .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .x(x0), .y(y0), .video_on(von0), .hsync(hs0), .vsync(vs0),
        .pixel_tick(pt0), .line_tick(lt0), .frame_tick(ft0)
    );

    vga_timing_gen #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                     .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .video_on(von1), .hsync(hs1), .vsync(vs1),
        .pixel_tick(pt1), .line_tick(lt1), .frame_tick(ft1)
    );

    int   n_chk = 0, n_fail = 0;
    int   n = 0;
    obs_t sb0[$], sb1[$];
    vec_t vecs[13];
    int   last_lt0, last_ft0, last_lt1, last_ft1;
    int   von_cnt, vs_cnt, hs_cnt;

    // Expected outputs after n clock edges since reset release, in closed form.
    function automatic obs_t model(int nn, int d);
        obs_t o;
        int   p, xi, yi;
        logic adv;
        p   = (d == 1) ? ((nn > 0) ? nn - 1 : 0) : nn / d;
        xi  = p % HT;
        yi  = (p / HT) % VT;
        adv = (d == 1) ? (nn > 1) : (nn > 0 && nn % d == 0);
        o.x   = 10'(xi);
        o.y   = 10'(yi);
        o.von = (nn > 0) && xi < HV && yi < VV;
        o.hs  = !((nn > 0) && xi >= HV + HFP && xi < HV + HFP + HSW);
        o.vs  = !((nn > 0) && yi >= VV + VFP && yi < VV + VFP + VSW);
        o.pt  = (d == 1) ? (nn > 0) : (nn % d == d - 1);
        o.lt  = adv && xi == 0;
        o.ft  = o.lt && yi == 0;
        return o;
    endfunction

    function automatic obs_t mk(int xv, int yv, bit von, bit hs, bit vs, bit pt, bit lt, bit ft);
        obs_t o;
        o = {10'(xv), 10'(yv), von, hs, vs, pt, lt, ft};
        return o;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic chk_obs(string name, obs_t act, obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d von=%b hs=%b vs=%b pt=%b lt=%b ft=%b expected x=%0d y=%0d von=%b hs=%b vs=%b pt=%b lt=%b ft=%b (n=%0d)",
                     name, act.x, act.y, act.von, act.hs, act.vs, act.pt, act.lt, act.ft,
                     exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.pt, exp.lt, exp.ft, n);
        end
    endtask

    task automatic restart_tracking();
        n = 0;
        sb0.delete();
        sb1.delete();
        last_lt0 = -1; last_ft0 = -1; last_lt1 = -1; last_ft1 = -1;
        von_cnt = 0; vs_cnt = 0; hs_cnt = 0;
    endtask

    task automatic check_vectors();
        foreach (vecs[i]) begin
            if (vecs[i].n == n) chk_obs("vec", obs0, vecs[i].e);
        end
    endtask

    task automatic step();
        obs_t e0, e1;
        @(posedge clk);
        n++;
        sb0.push_back(model(n, D));
        sb1.push_back(model(n, 1));
        @(negedge clk);
        e0 = sb0.pop_front();
        e1 = sb1.pop_front();
        chk_obs("cyc_div3", obs0, e0);
        chk_obs("cyc_div1", obs1, e1);
        check_vectors();
        if (lt0) begin
            if (last_lt0 >= 0) chk("line_spacing", n - last_lt0, HT * D);
            last_lt0 = n;
        end
        if (ft0) begin
            if (last_ft0 >= 0) begin
                chk("frame_spacing", n - last_ft0, HT * VT * D);
                chk("video_on_clks", von_cnt, HV * VV * D);
                chk("vsync_clks", vs_cnt, VSW * HT * D);
                chk("hsync_clks", hs_cnt, HSW * D * VT);
            end else begin
                chk("first_frame", n, HT * VT * D);
            end
            last_ft0 = n;
            von_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        end
        von_cnt += int'(von0);
        vs_cnt  += int'(!vs0);
        hs_cnt  += int'(!hs0);
        if (lt1) begin
            if (last_lt1 >= 0) chk("line_spacing_div1", n - last_lt1, HT);
            last_lt1 = n;
        end
        if (ft1) begin
            if (last_ft1 >= 0) chk("frame_spacing_div1", n - last_ft1, HT * VT);
            last_ft1 = n;
        end
    endtask

    initial begin
        vecs[0]  = '{0,   mk(0, 0, 0, 1, 1, 0, 0, 0)};
        vecs[1]  = '{2,   mk(0, 0, 1, 1, 1, 1, 0, 0)};
        vecs[2]  = '{3,   mk(1, 0, 1, 1, 1, 0, 0, 0)};
        vecs[3]  = '{30,  mk(10, 0, 0, 0, 1, 0, 0, 0)};
        vecs[4]  = '{39,  mk(13, 0, 0, 1, 1, 0, 0, 0)};
        vecs[5]  = '{45,  mk(0, 1, 1, 1, 1, 0, 1, 0)};
        vecs[6]  = '{46,  mk(0, 1, 1, 1, 1, 0, 0, 0)};
        vecs[7]  = '{150, mk(5, 3, 1, 1, 1, 0, 0, 0)};
        vecs[8]  = '{225, mk(0, 5, 0, 1, 0, 0, 1, 0)};
        vecs[9]  = '{357, mk(14, 7, 0, 1, 1, 0, 0, 0)};
        vecs[10] = '{359, mk(14, 7, 0, 1, 1, 1, 0, 0)};
        vecs[11] = '{360, mk(0, 0, 1, 1, 1, 0, 1, 1)};
        vecs[12] = '{361, mk(0, 0, 1, 1, 1, 0, 0, 0)};
        restart_tracking();

        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_x", int'(x0), 0);
        chk("rst_y", int'(y0), 0);
        chk("rst_hsync", int'(hs0), 1);
        chk("rst_vsync", int'(vs0), 1);
        chk("rst_video_on", int'(von0), 0);
        chk("rst_ticks", int'({pt0, lt0, ft0}), 0);
        chk("rst_ticks_div1", int'({pt1, lt1, ft1}), 0);

        rst_n = 1'b1;
        restart_tracking();
        check_vectors();
        repeat (2 * HT * VT * D + 60) step();

        for (int i = 0; i < 100 && x0 != 10'd4; i++) step();
        chk("find_x4", int'(x0), 4);
        #2 rst_n = 1'b0;
        #1;
        chk_obs("async_rst_div3", obs0, model(0, D));
        chk_obs("async_rst_div1", obs1, model(0, 1));
        repeat (2) @(negedge clk);
        chk_obs("rst_hold_div3", obs0, model(0, D));
        rst_n = 1'b1;
        restart_tracking();
        repeat (HT * VT * D + 10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
